// File: rtl/plic_axi_pkg.sv
// Shared definitions for the PLIC AXI4-Lite initiator: FSM states, AXI
// response codes, default bus widths and the PLIC register map.
package plic_axi_pkg;

  localparam int unsigned DEF_ADDR_W = 28;
  localparam int unsigned DEF_DATA_W = 64;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [27:0] PRIO_BASE   = 28'h000_0000;
  localparam logic [27:0] ENABLE_BASE = 28'h000_2000;
  localparam logic [27:0] CTX_BASE    = 28'h020_0000;
  localparam logic [27:0] CTX_STRIDE  = 28'h000_1000;

  typedef enum logic [2:0] {
    ST_IDLE,  // waiting for a command
    ST_WR,    // AW and/or W in flight
    ST_WB,    // waiting for B
    ST_RA,    // AR in flight
    ST_RD,    // waiting for R
    ST_RSP    // presenting the response
  } state_t;

  // Any response other than OKAY is reported as an error to the hart side.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/plic_axi_lite_master_if.sv
// AXI4-Lite channel bundle between the initiator and the PLIC wrapper slave.
interface plic_axi_lite_master_if #(
  parameter int unsigned ADDR_W = plic_axi_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = plic_axi_pkg::DEF_DATA_W
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/plic_axi_lite_master.sv
// AXI4-Lite initiator for the PLIC: converts one valid/ready command into
// exactly one AXI-Lite read or write and returns a single response.
// Only one transaction is ever outstanding.
module plic_axi_lite_master
  import plic_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  plic_axi_lite_master_if.master m_axi
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done;
  logic              w_done;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic cmd_hs;
  logic misaligned;
  logic aw_hs;
  logic w_hs;

  assign cmd_hs     = cmd_valid && (state == ST_IDLE);
  assign misaligned = cmd_addr[1:0] != 2'b00;
  assign aw_hs      = m_axi.awvalid && m_axi.awready;
  assign w_hs       = m_axi.wvalid && m_axi.wready;

  // State register.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Next-state: AW and W complete independently; WB is entered once both are done.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (cmd_hs) state_nxt = misaligned ? ST_RSP : (cmd_write ? ST_WR : ST_RA);
      ST_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WB;
      ST_WB:   if (m_axi.bvalid) state_nxt = ST_RSP;
      ST_RA:   if (m_axi.arready) state_nxt = ST_RD;
      ST_RD:   if (m_axi.rvalid) state_nxt = ST_RSP;
      ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state and flags, so no VALID depends on a READY.
  always_comb begin
    cmd_ready      = state == ST_IDLE;
    rsp_valid      = state == ST_RSP;
    rsp_rdata      = rdata_q;
    rsp_err        = err_q;
    m_axi.awaddr   = addr_q;
    m_axi.awprot   = '0;
    m_axi.awvalid  = (state == ST_WR) && !aw_done;
    m_axi.wdata    = wdata_q;
    m_axi.wstrb    = wstrb_q;
    m_axi.wvalid   = (state == ST_WR) && !w_done;
    m_axi.bready   = state == ST_WB;
    m_axi.araddr   = addr_q;
    m_axi.arprot   = '0;
    m_axi.arvalid  = state == ST_RA;
    m_axi.rready   = state == ST_RD;
  end

  // Command holding registers, captured on acceptance and stable for the whole transaction.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_hs) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Per-channel completion flags for the write address and write data beats.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (cmd_hs) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == ST_WR) begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Response holding registers; B/R arriving outside WB/RD never reach here.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (cmd_hs && misaligned) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
        ST_WB: if (m_axi.bvalid) begin
          rdata_q <= '0;
          err_q   <= resp_is_err(m_axi.bresp);
        end
        ST_RD: if (m_axi.rvalid) begin
          rdata_q <= m_axi.rdata;
          err_q   <= resp_is_err(m_axi.rresp);
        end
        ST_RSP: if (rsp_ready) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_axi_lite_master.sv
// Bench for plic_axi_lite_master: a timing-configurable AXI-Lite slave plus a
// transaction-level expectation of each command's response and bus traffic.
module tb_plic_axi_lite_master;
  import plic_axi_pkg::*;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  plic_axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  plic_axi_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .m_axi        (axi)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave timing/response configuration for the next transaction.
  int unsigned   cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  logic [1:0]    cfg_bresp, cfg_rresp;
  logic [63:0]   cfg_rdata;

  // Slave observations.
  int unsigned   aw_beats, w_beats, b_beats, ar_beats, r_beats, valid_cycles;
  logic [AW-1:0] last_awaddr, last_araddr;
  logic [DW-1:0] last_wdata;
  logic [SW-1:0] last_wstrb;
  logic [2:0]    last_awprot, last_arprot;

  task automatic set_cfg(input int unsigned awd, input int unsigned wd, input int unsigned bd,
                         input logic [1:0] br, input int unsigned ard, input int unsigned rd,
                         input logic [1:0] rr, input logic [63:0] rdat);
    cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd; cfg_bresp = br;
    cfg_ar_dly = ard; cfg_r_dly = rd; cfg_rresp = rr; cfg_rdata = rdat;
  endtask

  // AXI-Lite slave: acts at negedges; handshakes are those whose VALID and
  // READY were both high in the snapshot taken at the previous negedge.
  initial begin : slave
    logic          hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic          p_awvalid, p_wvalid, p_arvalid;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [SW-1:0] p_wstrb;
    logic [2:0]    p_awprot, p_arprot;
    int unsigned   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic          aw_got, w_got, r_pend;
    aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0; valid_cycles = 0;
    last_awaddr = '0; last_araddr = '0; last_wdata = '0; last_wstrb = '0;
    last_awprot = '0; last_arprot = '0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0; p_awprot = '0; p_arprot = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; r_pend = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rresp = '0; axi.rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; r_pend = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.arready = 0; axi.rvalid = 0;
      end else begin
        if (p_awvalid && !hs_aw) begin
          check("awvalid_hold", 64'(axi.awvalid), 64'd1);
          check("awaddr_stable", 64'(axi.awaddr), 64'(p_awaddr));
        end
        if (p_wvalid && !hs_w) begin
          check("wvalid_hold", 64'(axi.wvalid), 64'd1);
          check("wdata_stable", axi.wdata, p_wdata);
          check("wstrb_stable", 64'(axi.wstrb), 64'(p_wstrb));
        end
        if (p_arvalid && !hs_ar) begin
          check("arvalid_hold", 64'(axi.arvalid), 64'd1);
          check("araddr_stable", 64'(axi.araddr), 64'(p_araddr));
        end
        if (hs_aw) begin aw_beats++; last_awaddr = p_awaddr; last_awprot = p_awprot; aw_got = 1; end
        if (hs_w)  begin w_beats++;  last_wdata = p_wdata; last_wstrb = p_wstrb; w_got = 1; end
        if (hs_b)  begin b_beats++;  axi.bvalid = 0; end
        if (hs_ar) begin ar_beats++; last_araddr = p_araddr; last_arprot = p_arprot; r_pend = 1; r_cnt = 0; end
        if (hs_r)  begin r_beats++;  axi.rvalid = 0; end
        if (axi.awvalid || axi.wvalid || axi.arvalid) valid_cycles++;

        if (axi.awvalid) begin axi.awready = aw_cnt >= cfg_aw_dly; aw_cnt++; end
        else begin axi.awready = 0; aw_cnt = 0; end
        if (axi.wvalid) begin axi.wready = w_cnt >= cfg_w_dly; w_cnt++; end
        else begin axi.wready = 0; w_cnt = 0; end
        if (axi.arvalid) begin axi.arready = ar_cnt >= cfg_ar_dly; ar_cnt++; end
        else begin axi.arready = 0; ar_cnt = 0; end

        if (aw_got && w_got && !axi.bvalid) begin
          if (b_cnt >= cfg_b_dly) begin
            axi.bvalid = 1; axi.bresp = cfg_bresp; aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (r_pend) begin
          if (r_cnt >= cfg_r_dly) begin
            axi.rvalid = 1; axi.rdata = cfg_rdata; axi.rresp = cfg_rresp; r_pend = 0;
          end else r_cnt++;
        end

        hs_aw = axi.awvalid && axi.awready;
        hs_w  = axi.wvalid && axi.wready;
        hs_b  = axi.bvalid && axi.bready;
        hs_ar = axi.arvalid && axi.arready;
        hs_r  = axi.rvalid && axi.rready;
        p_awvalid = axi.awvalid; p_awaddr = axi.awaddr; p_awprot = axi.awprot;
        p_wvalid  = axi.wvalid;  p_wdata  = axi.wdata;  p_wstrb  = axi.wstrb;
        p_arvalid = axi.arvalid; p_araddr = axi.araddr; p_arprot = axi.arprot;
      end
    end
  end

  // One command end to end; expectations come from the command and slave config alone.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input int unsigned hold, input bit chk_lat);
    logic          aligned;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] got_rdata;
    logic          got_err;
    int unsigned   aw0, w0, b0, ar0, r0, v0, n;
    aligned   = addr[1:0] == 2'b00;
    exp_err   = !aligned || (wr ? (cfg_bresp != AXI_RESP_OKAY) : (cfg_rresp != AXI_RESP_OKAY));
    exp_rdata = (aligned && !wr) ? cfg_rdata : 64'd0;
    @(negedge clk);
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats; ar0 = ar_beats; r0 = r_beats; v0 = valid_cycles;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin check("cmd_ready_timeout", 64'd0, 64'd1); return; end
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    @(negedge clk);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
    cmd_wdata = {$urandom, $urandom}; cmd_wstrb = SW'($urandom);
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    n = 1;
    while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
    if (!rsp_valid) begin check("rsp_timeout", 64'd0, 64'd1); return; end
    if (chk_lat) check("latency", 64'(n), 64'd3);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    got_rdata = rsp_rdata; got_err = rsp_err;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_valid_held", 64'(rsp_valid), 64'd1);
      check("rsp_rdata_stable", rsp_rdata, got_rdata);
      check("rsp_err_stable", 64'(rsp_err), 64'(got_err));
      check("cmd_ready_in_rsp", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    check("aw_beats", 64'(aw_beats - aw0), 64'(aligned && wr));
    check("w_beats",  64'(w_beats - w0),   64'(aligned && wr));
    check("b_beats",  64'(b_beats - b0),   64'(aligned && wr));
    check("ar_beats", 64'(ar_beats - ar0), 64'(aligned && !wr));
    check("r_beats",  64'(r_beats - r0),   64'(aligned && !wr));
    check("any_valid_seen", 64'(valid_cycles != v0), 64'(aligned));
    if (aligned && wr) begin
      check("awaddr", 64'(last_awaddr), 64'(addr));
      check("awprot", 64'(last_awprot), 64'd0);
      check("wdata", last_wdata, wd);
      check("wstrb", 64'(last_wstrb), 64'(ws));
    end
    if (aligned && !wr) begin
      check("araddr", 64'(last_araddr), 64'(addr));
      check("arprot", 64'(last_arprot), 64'd0);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_cmd_ready);
    check({tag, "_awvalid"}, 64'(axi.awvalid), 64'd0);
    check({tag, "_wvalid"},  64'(axi.wvalid),  64'd0);
    check({tag, "_bready"},  64'(axi.bready),  64'd0);
    check({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
    check({tag, "_rready"},  64'(axi.rready),  64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(exp_cmd_ready));
  endtask

  // Reset asserted while waiting for B (write) or R (read).
  task automatic reset_mid(input logic wr);
    int unsigned n;
    set_cfg(0, 0, 30, AXI_RESP_OKAY, 0, 30, AXI_RESP_OKAY, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = CTX_BASE + CTX_STRIDE; cmd_wdata = 64'h55; cmd_wstrb = '1;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!(wr ? axi.bready : axi.rready) && n < 20) begin @(negedge clk); n++; end
    check(wr ? "reached_wb" : "reached_rd", 64'(wr ? axi.bready : axi.rready), 64'd1);
    #1 rst = 1;
    #1 check_quiet(wr ? "rst_wb" : "rst_rd", 1'b1);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet("after_rst", 1'b1);
    end
  endtask

  initial begin : watchdog
    #500000;
    check("watchdog", 64'd0, 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    logic          wr;
    logic [AW-1:0] addr;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    set_cfg(0, 0, 0, AXI_RESP_OKAY, 0, 0, AXI_RESP_OKAY, 64'd0);
    repeat (3) @(negedge clk);
    check_quiet("reset", 1'b1);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_awaddr", 64'(axi.awaddr), 64'd0);
    check("reset_araddr", 64'(axi.araddr), 64'd0);
    check("reset_wdata", axi.wdata, 64'd0);
    check("reset_wstrb", 64'(axi.wstrb), 64'd0);
    check("reset_prot", 64'({axi.awprot, axi.arprot}), 64'd0);
    rst = 0;

    // Zero-wait write, then AW late / W late.
    do_cmd(1, 28'h8, 64'h0000_0003_0000_0003, 8'hFF, 0, 1);
    set_cfg(4, 0, 0, AXI_RESP_OKAY, 0, 0, AXI_RESP_OKAY, 64'd0);
    do_cmd(1, ENABLE_BASE, 64'h0000_0000_0000_00F0, 8'h0F, 1, 0);
    set_cfg(0, 4, 0, AXI_RESP_OKAY, 0, 0, AXI_RESP_OKAY, 64'd0);
    do_cmd(1, ENABLE_BASE + 28'h8, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0);

    // Read with R two cycles after AR, plus a zero-wait read for latency.
    set_cfg(0, 0, 0, AXI_RESP_OKAY, 0, 1, AXI_RESP_OKAY, 64'h0E);
    do_cmd(0, CTX_BASE + 28'h4, '0, '0, 2, 0);
    set_cfg(0, 0, 0, AXI_RESP_OKAY, 0, 0, AXI_RESP_OKAY, 64'hA5A5_0000_1111_2222);
    do_cmd(0, PRIO_BASE + 28'h10, '0, '0, 0, 1);

    // Error responses.
    set_cfg(0, 0, 0, AXI_RESP_SLVERR, 0, 0, AXI_RESP_DECERR, 64'h77);
    do_cmd(1, CTX_BASE, 64'hFFFF_FFFF_0000_0000, 8'hF0, 0, 0);
    do_cmd(0, CTX_BASE, '0, '0, 0, 0);

    // Misaligned commands: no bus activity, error response held 5 cycles.
    set_cfg(0, 0, 0, AXI_RESP_OKAY, 0, 0, AXI_RESP_OKAY, 64'h99);
    do_cmd(1, 28'h3, 64'hCAFE, 8'hFF, 5, 0);
    do_cmd(0, 28'h2001, '0, '0, 5, 0);

    // Stray B/R while idle must be ignored.
    @(negedge clk);
    axi.bvalid = 1; axi.bresp = AXI_RESP_SLVERR; axi.rvalid = 1; axi.rresp = AXI_RESP_DECERR;
    repeat (2) begin
      @(negedge clk);
      check_quiet("stray", 1'b1);
    end
    axi.bvalid = 0; axi.rvalid = 0;
    set_cfg(0, 0, 0, AXI_RESP_OKAY, 0, 0, AXI_RESP_OKAY, 64'h0123_4567_89AB_CDEF);
    do_cmd(0, CTX_BASE + 28'h4, '0, '0, 0, 1);

    // Reset in WB and in RD, each followed by a clean read.
    reset_mid(1);
    set_cfg(0, 0, 0, AXI_RESP_OKAY, 0, 0, AXI_RESP_OKAY, 64'h1111_2222_3333_4444);
    do_cmd(0, 28'h40, '0, '0, 0, 1);
    reset_mid(0);
    set_cfg(0, 0, 0, AXI_RESP_OKAY, 0, 2, AXI_RESP_OKAY, 64'h5555_6666_7777_8888);
    do_cmd(0, 28'h44, '0, '0, 0, 0);

    // Randomized traffic.
    for (int unsigned t = 0; t < 40; t++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = AW'($urandom) & 28'hFFF_FFFC;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : AXI_RESP_OKAY,
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : AXI_RESP_OKAY,
              {$urandom, $urandom});
      do_cmd(wr, addr, {$urandom, $urandom}, SW'($urandom), $urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
